// File: rtl/kernel_launcher_pkg.sv
// Shared types for the kernel launcher: command modes, FSM states and mode decode.
package kernel_launcher_pkg;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_FREE   = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STALL = 2'd3
  } state_e;

  // Raw encoding 3 is reserved and runs as a single launch.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_COUNT;
      2'd2:    return MODE_FREE;
      default: return MODE_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/launcher_result_fifo.sv
// First-word-fall-through result FIFO; a push into a full FIFO succeeds when it is popped in the same cycle.
module launcher_result_fifo
  import kernel_launcher_pkg::*;
#(
  parameter int unsigned RET_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [RET_W-1:0] push_data,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [RET_W-1:0] res_data,
  output logic             full,
  output logic             pop_c
);

  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = ADDR_W + 1;

  logic [RET_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              valid_q, full_q;
  logic              push_ok;

  assign pop_c     = valid_q && res_ready;
  assign push_ok   = push && (!full_q || pop_c);
  assign res_valid = valid_q;
  assign full      = full_q;
  assign res_data  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_c)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    count_d = count_q + OCC_W'(push_ok) - OCC_W'(pop_c);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      full_q   <= (count_d == OCC_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/kernel_launcher.sv
// Launches a kernel once, N times or until aborted, and queues each return value in a result FIFO.
// Optional kernel watchdog: define KERNEL_LAUNCHER_TIMEOUT_EN.
module kernel_launcher
  import kernel_launcher_pkg::*;
#(
  parameter int unsigned RET_W       = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             start_port,
  input  logic             done_port,
  input  logic [RET_W-1:0] return_port,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RET_W-1:0] res_data,
  output logic             busy,
  output logic             batch_done,
  output logic             err_timeout
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [RET_W-1:0] skid_q, skid_d;
  logic             abort_pend_q, abort_pend_d;
  logic             batch_done_q, batch_done_d;
  logic             start_port_q, busy_q, cmd_ready_q;

  logic             fifo_push_c, fifo_full, fifo_pop_c, fifo_space_c;
  logic [RET_W-1:0] fifo_data_c;
  logic             run_end_c, abort_any_c, last_run_c;

`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign cmd_ready    = cmd_ready_q;
  assign start_port   = start_port_q;
  assign busy         = busy_q;
  assign batch_done   = batch_done_q;
  assign fifo_space_c = !fifo_full || fifo_pop_c;
  assign abort_any_c  = abort_pend_q || abort;
  assign last_run_c   = (mode_q == MODE_SINGLE) ||
                        ((mode_q == MODE_COUNT) && (remaining_q <= CNT_W'(1)));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    remaining_d  = remaining_q;
    skid_d       = skid_q;
    abort_pend_d = abort_pend_q;
    batch_done_d = 1'b0;
    fifo_push_c  = 1'b0;
    fifo_data_c  = return_port;
    run_end_c    = 1'b0;
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
    timer_d      = '0;
    err_d        = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          abort_pend_d = 1'b0;
          mode_d       = decode_mode(cmd_mode);
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
          err_d        = 1'b0;
`endif
          case (decode_mode(cmd_mode))
            MODE_COUNT: begin
              remaining_d = cmd_count;
              if (cmd_count == '0) batch_done_d = 1'b1;
              else                 state_d      = ST_START;
            end
            MODE_FREE: state_d = ST_START;
            default: begin
              remaining_d = CNT_W'(1);
              state_d     = ST_START;
            end
          endcase
        end
      end
      ST_START: begin
        abort_pend_d = abort_any_c;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        abort_pend_d = abort_any_c;
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
        timer_d      = timer_q + TMR_W'(1);
`endif
        if (done_port) begin
          if (fifo_space_c) begin
            fifo_push_c = 1'b1;
            run_end_c   = 1'b1;
          end else begin
            skid_d  = return_port;
            state_d = ST_STALL;
          end
        end
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
        else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          err_d        = 1'b1;
          batch_done_d = 1'b1;
          abort_pend_d = 1'b0;
          state_d      = ST_IDLE;
        end
`endif
      end
      ST_STALL: begin
        abort_pend_d = abort_any_c;
        fifo_data_c  = skid_q;
        if (fifo_space_c) begin
          fifo_push_c = 1'b1;
          run_end_c   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared tail after a result has been queued.
    if (run_end_c) begin
      if (mode_q == MODE_COUNT) remaining_d = remaining_q - CNT_W'(1);
      if (last_run_c || abort_any_c) begin
        state_d      = ST_IDLE;
        batch_done_d = 1'b1;
        abort_pend_d = 1'b0;
      end else begin
        state_d = ST_START;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_SINGLE;
      remaining_q  <= '0;
      skid_q       <= '0;
      abort_pend_q <= 1'b0;
      batch_done_q <= 1'b0;
      start_port_q <= 1'b0;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b1;
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
      timer_q      <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      remaining_q  <= remaining_d;
      skid_q       <= skid_d;
      abort_pend_q <= abort_pend_d;
      batch_done_q <= batch_done_d;
      start_port_q <= (state_d == ST_START);
      busy_q       <= (state_d != ST_IDLE);
      cmd_ready_q  <= (state_d == ST_IDLE);
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
      timer_q      <= timer_d;
      err_q        <= err_d;
`endif
    end
  end

  launcher_result_fifo #(
    .RET_W      (RET_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push_c),
    .push_data (fifo_data_c),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .full      (fifo_full),
    .pop_c     (fifo_pop_c)
  );

endmodule

// File: tb/tb_kernel_launcher.sv
// Directed bench for kernel_launcher: single, count, zero-count, free/abort, stall, watchdog and mid-batch reset.
module tb_kernel_launcher;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_count;
  logic        abort;
  logic        start_port;
  logic        done_port;
  logic [31:0] return_port;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;
  logic        batch_done;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int batches = 0;
  logic [31:0] got [$];

  always #5 clock = ~clock;

  kernel_launcher #(
    .RET_W       (32),
    .FIFO_DEPTH  (4),
    .CNT_W       (16),
    .TIMEOUT_CYC (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_count   (cmd_count),
    .abort       (abort),
    .start_port  (start_port),
    .done_port   (done_port),
    .return_port (return_port),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .batch_done  (batch_done),
    .err_timeout (err_timeout)
  );

  // Event monitor: start pulses, batch ends and every popped result.
  always @(posedge clock) begin
    if (!reset) begin
      if (start_port) starts <= starts + 1;
      if (batch_done) batches <= batches + 1;
      if (res_valid && res_ready) got.push_back(res_data);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] mode, input logic [15:0] cnt);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_count = cnt;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic kernel_done(input logic [31:0] v);
    done_port   = 1'b1;
    return_port = v;
    step();
    done_port   = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (start_port !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check(tag, 32'(start_port), 32'd1);
  endtask

  initial begin
    int s0, b0, g0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_count = '0;
    abort = 1'b0; done_port = 1'b0; return_port = '0; res_ready = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_start",     32'(start_port), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_batch",     32'(batch_done), 32'd0);
    check("rst_err",       32'(err_timeout), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // SINGLE launch, kernel returns 0xA5 five cycles after start
    s0 = starts; b0 = batches; g0 = got.size();
    send_cmd(2'd0, 16'd0);
    check("single_start_t1", 32'(start_port), 32'd1);
    check("single_busy",     32'(busy), 32'd1);
    check("single_ready",    32'(cmd_ready), 32'd0);
    step();
    check("single_start_one", 32'(start_port), 32'd0);
    repeat (3) step();
    kernel_done(32'hA5);
    check("single_res_valid", 32'(res_valid), 32'd1);
    check("single_res_data",  res_data, 32'hA5);
    check("single_batch",     32'(batch_done), 32'd1);
    check("single_idle",      32'(busy), 32'd0);
    step();
    check("single_batch_pulse", 32'(batch_done), 32'd0);
    repeat (3) step();
    check("single_starts",  32'(starts - s0), 32'd1);
    check("single_batches", 32'(batches - b0), 32'd1);
    check("single_results", 32'(got.size() - g0), 32'd1);

    // COUNT = 0: no launch, batch_done the cycle after acceptance
    s0 = starts;
    send_cmd(2'd1, 16'd0);
    check("cnt0_batch", 32'(batch_done), 32'd1);
    check("cnt0_start", 32'(start_port), 32'd0);
    check("cnt0_busy",  32'(busy), 32'd0);
    step();
    check("cnt0_batch_pulse", 32'(batch_done), 32'd0);
    check("cnt0_starts", 32'(starts - s0), 32'd0);

    // COUNT = 6 with the consumer stalled: four queued, fifth held in skid
    s0 = starts; g0 = got.size();
    res_ready = 1'b0;
    send_cmd(2'd1, 16'd6);
    for (int i = 0; i < 5; i++) begin
      wait_start("cnt6_start");
      step();
      kernel_done(32'h100 + 32'(i));
    end
    step();
    check("stall_no_start",  32'(start_port), 32'd0);
    check("stall_busy",      32'(busy), 32'd1);
    check("stall_res_valid", 32'(res_valid), 32'd1);
    check("stall_head",      res_data, 32'h100);
    repeat (20) step();
    check("stall_starts", 32'(starts - s0), 32'd5);
    check("stall_start_still", 32'(start_port), 32'd0);
    res_ready = 1'b1;
    step();
    wait_start("cnt6_start_last");
    step();
    kernel_done(32'h105);
    check("cnt6_batch", 32'(batch_done), 32'd1);
    repeat (8) step();
    check("cnt6_starts",  32'(starts - s0), 32'd6);
    check("cnt6_results", 32'(got.size() - g0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (g0 + i < got.size()) check("cnt6_order", got[g0 + i], 32'h100 + 32'(i));
    end

    // FREE mode, abort during the third WAIT
    s0 = starts; b0 = batches;
    send_cmd(2'd2, 16'd0);
    wait_start("free_start0"); step(); kernel_done(32'h201);
    wait_start("free_start1"); step(); kernel_done(32'h202);
    wait_start("free_start2"); step();
    abort = 1'b1; step(); abort = 1'b0;
    step();
    kernel_done(32'h203);
    check("abort_res_valid", 32'(res_valid), 32'd1);
    check("abort_res_data",  res_data, 32'h203);
    check("abort_batch",     32'(batch_done), 32'd1);
    check("abort_idle",      32'(busy), 32'd0);
    repeat (6) step();
    check("abort_starts",  32'(starts - s0), 32'd3);
    check("abort_batches", 32'(batches - b0), 32'd1);
    check("abort_last",    got[got.size() - 1], 32'h203);

    // abort while idle has no effect on the following COUNT = 2 batch
    s0 = starts;
    abort = 1'b1; step(); abort = 1'b0;
    send_cmd(2'd1, 16'd2);
    wait_start("idle_abort_s0"); step(); kernel_done(32'h401);
    wait_start("idle_abort_s1"); step(); kernel_done(32'h402);
    check("idle_abort_batch", 32'(batch_done), 32'd1);
    repeat (3) step();
    check("idle_abort_starts", 32'(starts - s0), 32'd2);

    // long WAIT without done_port: watchdog in the timeout build, indefinite wait otherwise
    send_cmd(2'd0, 16'd0);
    step();
    repeat (15) step();
    check("wd_pre_err",  32'(err_timeout), 32'd0);
    check("wd_pre_busy", 32'(busy), 32'd1);
    step();
`ifdef KERNEL_LAUNCHER_TIMEOUT_EN
    check("wd_err",       32'(err_timeout), 32'd1);
    check("wd_idle",      32'(busy), 32'd0);
    check("wd_batch",     32'(batch_done), 32'd1);
    check("wd_res_valid", 32'(res_valid), 32'd0);
    send_cmd(2'd1, 16'd0);
    check("wd_err_clear", 32'(err_timeout), 32'd0);
`else
    check("wd_err_tied", 32'(err_timeout), 32'd0);
    check("wd_waiting",  32'(busy), 32'd1);
    kernel_done(32'h501);
    check("wd_late_done", res_data, 32'h501);
    step();
`endif

    // reset mid-batch with two results queued
    res_ready = 1'b0;
    send_cmd(2'd1, 16'd5);
    wait_start("rst_s0"); step(); kernel_done(32'h301);
    wait_start("rst_s1"); step(); kernel_done(32'h302);
    wait_start("rst_s2"); step();
    check("rst_q_valid", 32'(res_valid), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("midrst_busy",      32'(busy), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_start",     32'(start_port), 32'd0);
    kernel_done(32'h3FF);
    check("late_done_valid", 32'(res_valid), 32'd0);
    check("late_done_busy",  32'(busy), 32'd0);
    step();
    check("late_done_start", 32'(start_port), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
